// File: rtl/trap_event_ctrl.sv
// Sequencing controller for the trapezoidal shaper: filter clear, crossing detect,
// rise/flat-top timing, amplitude capture and a one-entry valid/ready event register.
module trap_event_ctrl #(
  parameter int DATA_W   = 20,
  parameter int RISE_LEN = 8,
  parameter int FLAT_LEN = 4,
  parameter int HOLDOFF  = 16,
  parameter int CLR_LEN  = 32,
  parameter int TS_W     = 32,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] trap_data,
  input  logic [DATA_W-1:0] threshold,
  output logic              filter_rst_n,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [DATA_W-1:0] evt_amp,
  output logic [TS_W-1:0]   evt_ts,
  output logic              evt_pileup,
  output logic              busy,
  output logic [CNT_W-1:0]  lost_cnt,
  output logic [CNT_W-1:0]  reject_cnt
);

  localparam int MAX_LEN = (RISE_LEN > FLAT_LEN) ?
                           ((RISE_LEN > HOLDOFF) ? RISE_LEN : HOLDOFF) :
                           ((FLAT_LEN > HOLDOFF) ? FLAT_LEN : HOLDOFF);
  localparam int SC_W = $clog2(MAX_LEN + 1);
  localparam int CC_W = $clog2(CLR_LEN + 1);
  localparam logic [SC_W-1:0] RISE_LAST = SC_W'(RISE_LEN - 1);
  localparam logic [SC_W-1:0] FLAT_LAST = SC_W'(FLAT_LEN - 1);
  localparam logic [SC_W-1:0] FLAT_MID  = SC_W'(FLAT_LEN / 2);
  localparam logic [SC_W-1:0] HOLD_LAST = SC_W'(HOLDOFF - 1);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_RISE, S_FLAT, S_HOLDOFF} state_t;
  state_t state, state_d;

  logic [CC_W-1:0]   clr_cnt;
  logic              clr_done;
  logic [SC_W-1:0]   sc;
  logic [TS_W-1:0]   ts_cnt, ts_lat;
  logic [DATA_W-1:0] amp_lat, amp_now;
  logic              prev_above, above, crossing, pile_pend;
  logic              sc_clr, sc_inc, ts_take, cap_take, deliver, reject, pile_set;
  logic              load, lost_inc;

  assign clr_done = (clr_cnt == CC_W'(CLR_LEN));
  assign above    = $signed(trap_data) > $signed(threshold);
  assign crossing = sample_en && above && !prev_above;
  assign amp_now  = cap_take ? trap_data : amp_lat;
  assign load     = deliver && (!evt_valid || evt_ready);
  assign lost_inc = deliver && evt_valid && !evt_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_cnt      <= '0;
      filter_rst_n <= 1'b0;
    end else if (!enable) begin
      clr_cnt      <= '0;
      filter_rst_n <= 1'b0;
    end else begin
      if (!clr_done) clr_cnt <= clr_cnt + 1'b1;
      filter_rst_n <= clr_done;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d  = state;
    sc_clr   = 1'b0;
    sc_inc   = 1'b0;
    ts_take  = 1'b0;
    cap_take = 1'b0;
    deliver  = 1'b0;
    reject   = 1'b0;
    pile_set = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (clr_done) state_d = S_ARMED;
        S_ARMED: if (crossing) begin
          state_d = S_RISE;
          sc_clr  = 1'b1;
          ts_take = 1'b1;
        end
        S_RISE: if (sample_en) begin
          if (!above) begin
            reject  = 1'b1;
            state_d = S_ARMED;
          end else if (sc == RISE_LAST) begin
            state_d = S_FLAT;
            sc_clr  = 1'b1;
          end else begin
            sc_inc = 1'b1;
          end
        end
        S_FLAT: if (sample_en) begin
          if (!above) begin
            reject  = 1'b1;
            state_d = S_ARMED;
          end else begin
            cap_take = (sc == FLAT_MID);
            if (sc == FLAT_LAST) begin
              deliver = 1'b1;
              state_d = S_HOLDOFF;
              sc_clr  = 1'b1;
            end else begin
              sc_inc = 1'b1;
            end
          end
        end
        S_HOLDOFF: if (sample_en) begin
          pile_set = crossing;
          if (sc == HOLD_LAST) state_d = S_ARMED;
          else                 sc_inc  = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sc         <= '0;
      ts_cnt     <= '0;
      ts_lat     <= '0;
      amp_lat    <= '0;
      prev_above <= 1'b1;
      pile_pend  <= 1'b0;
      evt_valid  <= 1'b0;
      evt_amp    <= '0;
      evt_ts     <= '0;
      evt_pileup <= 1'b0;
      busy       <= 1'b0;
      lost_cnt   <= '0;
      reject_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      // Re-arming from IDLE treats the stream as already high, so no stale crossing fires.
      if (state == S_IDLE) prev_above <= 1'b1;
      else if (sample_en)  prev_above <= above;
      if (sc_clr)      sc <= '0;
      else if (sc_inc) sc <= sc + 1'b1;
      if (ts_take)  ts_lat  <= ts_cnt;
      if (cap_take) amp_lat <= trap_data;
      if (!enable || deliver) pile_pend <= 1'b0;
      else if (pile_set)      pile_pend <= 1'b1;
      if (load) begin
        evt_valid  <= 1'b1;
        evt_amp    <= amp_now;
        evt_ts     <= ts_lat;
        evt_pileup <= pile_pend;
      end else if (evt_ready) begin
        evt_valid <= 1'b0;
      end
      if (lost_inc && lost_cnt != '1) lost_cnt <= lost_cnt + 1'b1;
      if (reject && reject_cnt != '1) reject_cnt <= reject_cnt + 1'b1;
      busy <= (state_d == S_RISE) || (state_d == S_FLAT) || (state_d == S_HOLDOFF);
    end
  end

endmodule
